// File: rtl/jamma_joy_scanner.sv
// Time-multiplexed JAMMA control scanner: walks the player-select lines, waits a settle
// time, samples the shared active-low bus, debounces per player and strobes changes.
module jamma_joy_scanner #(
   parameter int PLAYERS  = 2,
   parameter int SEL_W    = 2,
   parameter int JOY_W    = 8,
   parameter int SETTLE   = 1,
   parameter int DB_COUNT = 2
) (
   input  logic                       pclk,
   input  logic                       reset,
   input  logic                       enable,
   input  logic [JOY_W-1:0]           jjoy,
   input  logic [JOY_W-1:0]           local_mask,
   output logic [SEL_W-1:0]           jsel,
   output logic [PLAYERS*JOY_W-1:0]   joy_out,
   output logic [PLAYERS-1:0]         changed,
   output logic                       scan_done
);

   localparam logic [7:0]       SET_LAST = 8'(SETTLE);
   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(PLAYERS - 1);
   localparam logic [3:0]       DB       = 4'(DB_COUNT);

   logic [7:0] slot_cnt;
   logic       sample;

   assign sample = enable && (slot_cnt == SET_LAST);

   always_ff @(posedge pclk) begin
      if (reset) begin
         slot_cnt  <= '0;
         jsel      <= '0;
         scan_done <= 1'b0;
      end else begin
         scan_done <= sample && (jsel == SEL_LAST);
         if (sample) begin
            slot_cnt <= '0;
            jsel     <= (jsel == SEL_LAST) ? '0 : jsel + SEL_W'(1);
         end else if (enable) begin
            slot_cnt <= slot_cnt + 8'd1;
         end
      end
   end

   logic [PLAYERS-1:0][JOY_W-1:0] joy_w;
   assign joy_out = joy_w;

   for (genvar p = 0; p < PLAYERS; p++) begin : g_lane
      logic [JOY_W-1:0] raw, last_raw, joy_r;
      logic [3:0]       cnt, cnt_nxt;
      logic             smp, chg_r;

      // Only the local player's sample sees the override mask.
      if (p == 0) begin : g_mask
         assign raw = jjoy & local_mask;
      end else begin : g_nomask
         assign raw = jjoy;
      end

      assign smp        = sample && (jsel == SEL_W'(p));
      assign joy_w[p]   = joy_r;
      assign changed[p] = chg_r;

      // Any bit difference restarts the run for the whole word.
      always_comb begin
         cnt_nxt = 4'd1;
         if (raw == last_raw)
            cnt_nxt = (cnt >= DB) ? DB : cnt + 4'd1;
      end

      always_ff @(posedge pclk) begin
         if (reset) begin
            last_raw <= '1;
            cnt      <= DB;
            joy_r    <= '1;
            chg_r    <= 1'b0;
         end else begin
            chg_r <= 1'b0;
            if (smp) begin
               last_raw <= raw;
               cnt      <= cnt_nxt;
               if (cnt_nxt == DB && raw != joy_r) begin
                  joy_r <= raw;
                  chg_r <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_jamma_joy_scanner.sv
// Bench for jamma_joy_scanner: directed sequences on three configurations, a legacy
// vector table, and a randomized run against a sample-history reference model.
module tb_jamma_joy_scanner;

   logic pclk = 1'b0;
   always #5 pclk = ~pclk;

   int checks   = 0;
   int failures = 0;

   // A: 2 players, SETTLE=1, DB_COUNT=3
   logic        rst_a, en_a;
   logic [7:0]  mask_a, jjoy_a;
   logic [7:0]  pat_a [4];
   logic [1:0]  jsel_a, chg_a;
   logic [15:0] joy_a;
   logic        done_a;
   always_comb jjoy_a = pat_a[jsel_a];

   jamma_joy_scanner #(.PLAYERS(2), .SEL_W(2), .JOY_W(8), .SETTLE(1), .DB_COUNT(3)) u_a (
      .pclk(pclk), .reset(rst_a), .enable(en_a), .jjoy(jjoy_a), .local_mask(mask_a),
      .jsel(jsel_a), .joy_out(joy_a), .changed(chg_a), .scan_done(done_a));

   // B: legacy splitter, SETTLE=0, DB_COUNT=1
   logic        rst_b, en_b;
   logic [7:0]  mask_b, jjoy_b;
   logic [7:0]  pat_b [4];
   logic [1:0]  jsel_b, chg_b;
   logic [15:0] joy_b;
   logic        done_b;
   always_comb jjoy_b = pat_b[jsel_b];

   jamma_joy_scanner #(.PLAYERS(2), .SEL_W(2), .JOY_W(8), .SETTLE(0), .DB_COUNT(1)) u_b (
      .pclk(pclk), .reset(rst_b), .enable(en_b), .jjoy(jjoy_b), .local_mask(mask_b),
      .jsel(jsel_b), .joy_out(joy_b), .changed(chg_b), .scan_done(done_b));

   // C: 3 players, SETTLE=2, DB_COUNT=2
   logic        rst_c, en_c;
   logic [7:0]  mask_c, jjoy_c;
   logic [7:0]  pat_c [4];
   logic [1:0]  jsel_c;
   logic [2:0]  chg_c;
   logic [23:0] joy_c;
   logic        done_c;
   always_comb jjoy_c = pat_c[jsel_c];

   jamma_joy_scanner #(.PLAYERS(3), .SEL_W(2), .JOY_W(8), .SETTLE(2), .DB_COUNT(2)) u_c (
      .pclk(pclk), .reset(rst_c), .enable(en_c), .jjoy(jjoy_c), .local_mask(mask_c),
      .jsel(jsel_c), .joy_out(joy_c), .changed(chg_c), .scan_done(done_c));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge pclk);
         #1;
      end
   endtask

   // Reference model for A: a sample happens on every (SETTLE+1)-th enabled cycle, the
   // player is picked by the slot index, and a word is accepted once its last DB_COUNT
   // samples are identical.
   localparam int RS = 1, RP = 2, RDB = 3;
   int         et;
   logic [7:0] mj   [RP];
   logic [7:0] hist [RP][RDB];
   logic [1:0] e_chg;
   logic       e_done;

   task automatic model_reset();
      et = 0;
      e_chg = '0;
      e_done = 1'b0;
      for (int p = 0; p < RP; p++) begin
         mj[p] = 8'hFF;
         for (int k = 0; k < RDB; k++) hist[p][k] = 8'hFF;
      end
   endtask

   task automatic model_step();
      int p;
      logic [7:0] raw;
      bit stable;
      if (rst_a) begin
         model_reset();
      end else begin
         e_chg = '0;
         e_done = 1'b0;
         if (en_a) begin
            if (et % (RS + 1) == RS) begin
               p = (et / (RS + 1)) % RP;
               raw = (p == 0) ? (pat_a[p] & mask_a) : pat_a[p];
               for (int k = 0; k < RDB - 1; k++) hist[p][k] = hist[p][k+1];
               hist[p][RDB-1] = raw;
               stable = 1'b1;
               for (int k = 0; k < RDB; k++) if (hist[p][k] != raw) stable = 1'b0;
               if (stable && raw != mj[p]) begin
                  mj[p] = raw;
                  e_chg[p] = 1'b1;
               end
               e_done = (p == RP - 1);
            end
            et++;
         end
      end
   endtask

   function automatic logic [7:0] pick();
      logic [31:0] v;
      v = $urandom;
      case ($urandom_range(0, 3))
         0: return 8'hFF;
         1: return 8'hFE;
         2: return 8'h7F;
         default: return v[7:0];
      endcase
   endfunction

   typedef struct {
      logic [7:0]  p0, p1;
      logic [1:0]  sel;
      logic [15:0] joy;
      logic [1:0]  chg;
      logic        done;
   } vec_t;

   initial begin
      vec_t lv [8];
      int   seq_a [8];
      int   seq_c [9];
      int   pulses, bad, dn;

      lv[0] = '{8'hFE, 8'h7F, 2'd1, 16'hFFFE, 2'b01, 1'b0};
      lv[1] = '{8'hFE, 8'h7F, 2'd0, 16'h7FFE, 2'b10, 1'b1};
      lv[2] = '{8'hFE, 8'h7F, 2'd1, 16'h7FFE, 2'b00, 1'b0};
      lv[3] = '{8'hFE, 8'h7F, 2'd0, 16'h7FFE, 2'b00, 1'b1};
      lv[4] = '{8'hFF, 8'h7F, 2'd1, 16'h7FFF, 2'b01, 1'b0};
      lv[5] = '{8'hFF, 8'h00, 2'd0, 16'h00FF, 2'b10, 1'b1};
      lv[6] = '{8'h0F, 8'h00, 2'd1, 16'h000F, 2'b01, 1'b0};
      lv[7] = '{8'h0F, 8'h00, 2'd0, 16'h000F, 2'b00, 1'b1};
      seq_a = '{0, 1, 1, 0, 0, 1, 1, 0};
      seq_c = '{0, 0, 1, 1, 1, 2, 2, 2, 0};

      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
      mask_a = 8'hFF; mask_b = 8'hFF; mask_c = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         pat_a[i] = 8'hFF; pat_b[i] = 8'hFF; pat_c[i] = 8'hFF;
      end

      // reset values and select sequence
      tick(3);
      chk("rst_jsel", 32'(jsel_a), 32'd0);
      chk("rst_joy", 32'(joy_a), 32'h0000FFFF);
      chk("rst_chg", 32'(chg_a), 32'd0);
      chk("rst_done", 32'(done_a), 32'd0);
      rst_a = 1'b0;
      chk("seq_jsel_first", 32'(jsel_a), 32'd0);
      for (int i = 0; i < 8; i++) begin
         tick(1);
         chk("seq_jsel", 32'(jsel_a), 32'(seq_a[i]));
         chk("seq_done", 32'(done_a), (i % 4 == 3) ? 32'd1 : 32'd0);
      end

      // debounce: two frames of FB are rejected, three are accepted
      pulses = 0;
      pat_a[1] = 8'hFB;
      for (int i = 0; i < 8; i++) begin tick(1); pulses += int'(chg_a[1]); end
      pat_a[1] = 8'hFF;
      for (int i = 0; i < 12; i++) begin tick(1); pulses += int'(chg_a[1]); end
      pat_a[1] = 8'hFB;
      for (int i = 0; i < 11; i++) begin tick(1); pulses += int'(chg_a[1]); end
      chk("db_hold", 32'(joy_a[15:8]), 32'hFF);
      chk("db_nopulse", 32'(pulses), 32'd0);
      tick(1);
      pulses += int'(chg_a[1]);
      chk("db_update", 32'(joy_a[15:8]), 32'hFB);
      chk("db_chg", 32'(chg_a), 32'b10);
      for (int i = 0; i < 4; i++) begin tick(1); pulses += int'(chg_a[1]); end
      chk("db_onepulse", 32'(pulses), 32'd1);

      // local mask hits player 0 only
      mask_a = 8'hDF;
      pat_a[1] = 8'hFF;
      tick(12);
      chk("mask_joy", 32'(joy_a), 32'h0000FFDF);

      // pause mid-slot, then the slot finishes after its remaining count
      tick(1);
      en_a = 1'b0;
      pat_a[0] = 8'h00;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk("pause_jsel", 32'(jsel_a), 32'd0);
         chk("pause_chg", 32'(chg_a), 32'd0);
         chk("pause_done", 32'(done_a), 32'd0);
         chk("pause_joy", 32'(joy_a), 32'h0000FFDF);
      end
      en_a = 1'b1;
      tick(1);
      chk("resume_jsel", 32'(jsel_a), 32'd1);
      tick(2);
      chk("resume_done", 32'(done_a), 32'd1);
      pat_a[0] = 8'hFF;

      // legacy splitter vectors
      chk("leg_rst_joy", 32'(joy_b), 32'h0000FFFF);
      rst_b = 1'b0;
      for (int i = 0; i < 8; i++) begin
         pat_b[0] = lv[i].p0;
         pat_b[1] = lv[i].p1;
         tick(1);
         chk("leg_jsel", 32'(jsel_b), 32'(lv[i].sel));
         chk("leg_joy", 32'(joy_b), 32'(lv[i].joy));
         chk("leg_chg", 32'(chg_b), 32'(lv[i].chg));
         chk("leg_done", 32'(done_b), 32'(lv[i].done));
      end

      // three players
      rst_c = 1'b0;
      for (int i = 0; i < 9; i++) begin
         tick(1);
         chk("p3_jsel", 32'(jsel_c), 32'(seq_c[i]));
         chk("p3_done", 32'(done_c), (i == 8) ? 32'd1 : 32'd0);
      end
      bad = 0; dn = 0;
      for (int i = 0; i < 27; i++) begin
         tick(1);
         if (jsel_c == 2'd3) bad++;
         dn += int'(done_c);
      end
      chk("p3_no_sel3", 32'(bad), 32'd0);
      chk("p3_done_count", 32'(dn), 32'd3);
      pat_c[2] = 8'h55;
      tick(18);
      chk("p3_joy", 32'(joy_c), 32'h0055FFFF);
      tick(4);
      chk("p3_midslot_jsel", 32'(jsel_c), 32'd1);
      rst_c = 1'b1;
      en_c = 1'b0;
      tick(1);
      chk("p3_rst_jsel", 32'(jsel_c), 32'd0);
      chk("p3_rst_joy", 32'(joy_c), 32'h00FFFFFF);
      chk("p3_rst_chg", 32'(chg_c), 32'd0);
      chk("p3_rst_done", 32'(done_c), 32'd0);
      rst_c = 1'b0;
      en_c = 1'b1;
      pat_c[2] = 8'hFF;
      tick(2);
      chk("p3_post_rst_hold", 32'(jsel_c), 32'd0);
      tick(1);
      chk("p3_post_rst_adv", 32'(jsel_c), 32'd1);

      // randomized run against the reference model
      rst_a = 1'b1;
      tick(1);
      model_reset();
      rst_a = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         rst_a = ($urandom_range(0, 499) == 0);
         en_a  = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 23) == 0) pat_a[$urandom_range(0, 1)] = pick();
         if ($urandom_range(0, 99) == 0) mask_a = ($urandom_range(0, 1) == 0) ? 8'hFF : pick();
         tick(1);
         model_step();
         chk("rnd_jsel", 32'(jsel_a), 32'((et / (RS + 1)) % RP));
         chk("rnd_joy", 32'(joy_a), 32'({mj[1], mj[0]}));
         chk("rnd_chg", 32'(chg_a), 32'(e_chg));
         chk("rnd_done", 32'(done_a), 32'(e_done));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/jamma_joy_scanner.md
# jamma_joy_scanner

Time-multiplexed JAMMA control scanner for arcade cores on the ZX-UNO carrier. Drives the external player-select lines, waits a programmable settle time, samples the shared active-low control bus for each player in turn, applies per-player debounce and a local override mask, and presents stable per-player control words to the core. It replaces the fixed two-player toggle-every-clock splitter. It adds:
- N players
- settle delay
- debounce
- scan pausing
- change/frame strobes

## Interface
Parameters:
- PLAYERS, 2, number of players scanned; legal range 1..4.
- SEL_W, 2, width of the select bus; must satisfy 2^SEL_W >= PLAYERS.
- JOY_W, 8, bits per player control word; active-low.
- SETTLE, 1, extra cycles `jsel` is held before sampling; legal range 0..255.
- DB_COUNT, 2, consecutive identical samples required before `joy_out` updates; legal range 1..15; 1 disables debounce.

Ports:
- pclk  in  1  system clock; sole clock domain.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  scan enable; low freezes scanning and holds all outputs.
- jjoy  in  JOY_W  raw shared control bus from the connector; active-low; already synchronised.
- local_mask  in  JOY_W  AND-mask applied to player 0 samples only; all-ones means no effect.
- jsel  out  SEL_W  binary index of the player currently addressed.
- joy_out  out  PLAYERS*JOY_W  debounced words; player p at [p*JOY_W +: JOY_W]; active-low.
- changed  out  PLAYERS  1-cycle pulse per player when its `joy_out` word updates.
- scan_done  out  1  1-cycle pulse when the last player of a frame has been sampled.

## Operation
- Slot FSM, one player per slot:
  - `slot_cnt` counts 0..SETTLE.
  - The edge where `slot_cnt == SETTLE` is the sample edge: `jjoy` is captured, `slot_cnt` returns to 0, and `jsel` advances.
  - `jsel` runs 0..PLAYERS-1, then wraps to 0. Codes >= PLAYERS are never driven.
- Sample value `raw`:
  - Player 0: `jjoy & local_mask`.
  - Other players: `jjoy`.
- Per-player debounce state: `last_raw[p]` (JOY_W bits) and `cnt[p]`, which saturates at DB_COUNT.
- On the sample edge for player p:
  - If `raw == last_raw[p]`: `cnt` becomes min(`cnt`+1, DB_COUNT).
  - Otherwise: `cnt` becomes 1 and `last_raw` takes `raw`.
  - If the new `cnt == DB_COUNT` and `raw != joy_out[p]`: `joy_out[p]` takes `raw` and `changed[p]` is set for one cycle.
- Comparison is word-wide. Any bit difference restarts the count for the whole word.
- `scan_done` is registered high on the sample edge of player PLAYERS-1 and cleared on the next edge.
- PLAYERS=1: `jsel` stays 0 permanently; `scan_done` pulses once per slot.
- `enable` low:
  - `slot_cnt`, `jsel` and the debounce state hold.
  - No sample is taken.
  - `changed` and `scan_done` are forced 0.
  - When `enable` returns high, scanning resumes from the frozen `slot_cnt`; the slot is neither restarted nor skipped.
- Reset, including mid-slot or mid-debounce, sets the following on the next edge and overrides `enable`:
  - `jsel` = 0, `slot_cnt` = 0.
  - `joy_out` = all ones, `last_raw` = all ones, `cnt` = DB_COUNT.
  - `changed` = 0, `scan_done` = 0.

## Timing
- Slot length: SETTLE+1 cycles.
- Frame length: PLAYERS*(SETTLE+1) cycles while `enable` is high.
- `jsel` is registered and changes only on sample edges. The connector therefore sees the new select for SETTLE+1 full cycles before that player is sampled.
- `joy_out`, `changed` and `scan_done` update on the same sample edge. All outputs are registered, with no combinational path from inputs.
- Latency from a stable `jjoy` change for player p to `joy_out[p]`:
  - Minimum: DB_COUNT-1 frames plus the wait to the next p slot.
  - Maximum: DB_COUNT frames.
- SETTLE=0, PLAYERS=2, DB_COUNT=1 reproduces the legacy splitter: `jsel` toggles every cycle and each word is captured every second cycle.

## Test plan
- Reset/sequence: hold `reset` for 3 cycles, with PLAYERS=2 and SETTLE=1 -> `jsel`=0, `joy_out`=16'hFFFF, `changed`=0, `scan_done`=0. After release, `jsel` reads 0,0,1,1,0,0 and `scan_done` pulses every 4 cycles.
- Legacy mode: SETTLE=0, DB_COUNT=1; drive `jjoy`=8'hFE when `jsel`=0 and 8'h7F when `jsel`=1 -> `joy_out`=16'h7FFE within 2 cycles; `changed`=2'b01 then 2'b10.
- Debounce: DB_COUNT=3; player 1 `jjoy`=8'hFB for 2 frames, then 8'hFF -> `joy_out[15:8]` stays 8'hFF with no `changed`. Holding 8'hFB for 3 frames -> update on the 3rd sample edge and exactly one `changed[1]` pulse.
- Mask: `local_mask`=8'hDF, `jjoy`=8'hFF -> `joy_out[7:0]`=8'hDF, `joy_out[15:8]`=8'hFF.
- Pause: drop `enable` for 10 cycles mid-slot -> `jsel` frozen, no strobes, `joy_out` held. On resume, the slot completes after the remaining count.
- Three players: PLAYERS=3, SEL_W=2, SETTLE=2 -> `jsel` reads 0,1,2,0 and never 3; `scan_done` every 9 cycles. Asserting `reset` mid-settle -> all reset values on the next edge.
